muldiv_unit: RTL

Iterative multiply/divide unit for the MIPS execute stage. It sits beside `alu` and accepts the same `a`/`b` operands from the ID/EX register. It runs MULT, MULTU, DIV and DIVU over multiple cycles and owns the architectural HI/LO registers. Their contents feed the EX result mux for MFHI/MFLO, and the pipeline hazard unit stalls on `busy`.

---
 rtl/mipspkg.sv | 27 ++
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_core.sv | 44 ++++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mipspkg.sv
// ---------------------------------------------------------------
// mipspkg: shared MIPS datapath types and widths. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package mipspkg;

  localparam int DATAWIDTH   = 32;
  localparam int MULDIV_ITER = DATAWIDTH;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  function automatic logic [DATAWIDTH-1:0] magnitude(input logic [DATAWIDTH-1:0] v,
                                                     input logic                 neg);
    return neg ? -v : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------
// muldiv_unit_if: request/result bundle of muldiv_unit. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface muldiv_unit_if;
  import mipspkg::*;

  logic                 start;
  muldiv_op_t           op;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic                 busy;
  logic                 done;
  logic                 divzero;
  logic [DATAWIDTH-1:0] hi;
  logic [DATAWIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, divzero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, divzero, hi, lo);

endinterface

`default_nettype wire

// File: rtl/muldiv_core.sv
// ---------------------------------------------------------------
// muldiv_core: one shift-add or restoring-divide step. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module muldiv_core
  import mipspkg::*;
(
  input  logic                 div_mode,
  input  logic [DATAWIDTH:0]   rem_in,
  input  logic [DATAWIDTH-1:0] low_in,
  input  logic [DATAWIDTH-1:0] operand,
  output logic [DATAWIDTH:0]   rem_out,
  output logic [DATAWIDTH-1:0] low_out
);

  logic [DATAWIDTH:0]   w_sum;
  logic [DATAWIDTH:0]   w_shifted;
  logic [DATAWIDTH+1:0] w_trial;

  always_comb begin
    w_sum     = rem_in + (low_in[0] ? {1'b0, operand} : '0);
    w_shifted = {rem_in[DATAWIDTH-1:0], low_in[DATAWIDTH-1]};
    // One extra bit so a negative trial difference shows up as the top bit
    w_trial   = {1'b0, w_shifted} - {2'b00, operand};
    rem_out   = '0;
    low_out   = '0;
    if (div_mode) begin
      if (w_trial[DATAWIDTH+1]) begin
        rem_out = w_shifted;
        low_out = {low_in[DATAWIDTH-2:0], 1'b0};
      end else begin
        rem_out = w_trial[DATAWIDTH:0];
        low_out = {low_in[DATAWIDTH-2:0], 1'b1};
      end
    end else begin
      rem_out = {1'b0, w_sum[DATAWIDTH:1]};
      low_out = {w_sum[0], low_in[DATAWIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------
// muldiv_unit: iterative MULT/DIV with architectural HI/LO. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module muldiv_unit
  import mipspkg::*;
(
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam int               CNT_W     = $clog2(MULDIV_ITER);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULDIV_ITER - 1);

  state_t                 r_state, w_next;
  logic [CNT_W-1:0]       r_count;
  logic [DATAWIDTH:0]     r_rem, w_rem_step;
  logic [DATAWIDTH-1:0]   r_low, w_low_step, r_operand, r_hi, r_lo;
  logic                   r_div_mode, r_neg_low, r_neg_high, r_done, r_divzero;
  logic                   w_signed, w_neg_a, w_neg_b, w_is_mul, w_is_div, w_iterative;
  logic [DATAWIDTH-1:0]   w_mag_a, w_mag_b, w_quot, w_remd;
  logic [2*DATAWIDTH-1:0] w_prod;

  muldiv_core u_core (
    .div_mode (r_div_mode),
    .rem_in   (r_rem),
    .low_in   (r_low),
    .operand  (r_operand),
    .rem_out  (w_rem_step),
    .low_out  (w_low_step)
  );

  always_comb begin
    w_signed    = (bus.op == MULT) || (bus.op == DIV);
    w_neg_a     = w_signed & bus.a[DATAWIDTH-1];
    w_neg_b     = w_signed & bus.b[DATAWIDTH-1];
    w_mag_a     = magnitude(bus.a, w_neg_a);
    w_mag_b     = magnitude(bus.b, w_neg_b);
    w_is_mul    = (bus.op == MULT) || (bus.op == MULTU);
    w_is_div    = (bus.op == DIV) || (bus.op == DIVU);
    w_iterative = w_is_mul || (w_is_div && (bus.b != '0));
    w_prod      = {r_rem[DATAWIDTH-1:0], r_low};
    if (r_neg_low) w_prod = -w_prod;
    w_quot      = magnitude(r_low, r_neg_low);
    w_remd      = magnitude(r_rem[DATAWIDTH-1:0], r_neg_high);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start && w_iterative) w_next = S_RUN;
      S_RUN:   if (r_count == LAST_ITER) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_rem      <= '0;
      r_low      <= '0;
      r_operand  <= '0;
      r_div_mode <= 1'b0;
      r_neg_low  <= 1'b0;
      r_neg_high <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_divzero  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_iterative) begin
              // Multiply keeps the multiplier in the low half; divide keeps the dividend there
              r_count    <= '0;
              r_rem      <= '0;
              r_low      <= w_is_div ? w_mag_a : w_mag_b;
              r_operand  <= w_is_div ? w_mag_b : w_mag_a;
              r_div_mode <= w_is_div;
              r_neg_low  <= w_neg_a ^ w_neg_b;
              r_neg_high <= w_neg_a;
            end else if (w_is_div) begin
              r_hi      <= bus.a;
              r_lo      <= '1;
              r_done    <= 1'b1;
              r_divzero <= 1'b1;
            end else if (bus.op == MTHI) begin
              r_hi   <= bus.a;
              r_done <= 1'b1;
            end else if (bus.op == MTLO) begin
              r_lo   <= bus.a;
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_rem   <= w_rem_step;
          r_low   <= w_low_step;
          r_count <= r_count + 1'b1;
        end
        S_FIX: begin
          if (r_div_mode) begin
            r_lo <= w_quot;
            r_hi <= w_remd;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_IDLE) && bus.start)
      assert (bus.op inside {MULT, MULTU, DIV, DIVU, MTHI, MTLO})
        else $error("muldiv_unit: start with undefined op %0d", bus.op);
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.divzero = r_divzero;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;

endmodule

`default_nettype wire
